// File: rtl/stat_display_pkg.sv
// stat_display_pkg: source-select encodings, FSM states, segment table and decimal saturation limit
package stat_display_pkg;
  typedef enum logic [2:0] {SEL_TOTAL, SEL_UNCOND, SEL_COND, SEL_COND_SUC, SEL_SYSCALL} sel_e;
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_e;
  localparam logic [31:0] BCD_SAT = 32'd99999999;
  localparam logic [15:0][7:0] SEG_TBL = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
endpackage

// File: rtl/stat_display_if.sv
// stat_display_if: statistic inputs from the pipeline and 7-segment display outputs
interface stat_display_if;
  logic [31:0] total_cycles, uncondi_num, condi_num, condi_suc_num, syscall_out;
  logic        halt;
  logic [2:0]  sel;
  logic [7:0]  seg, an;
  logic        busy;
  modport master (
    output total_cycles, uncondi_num, condi_num, condi_suc_num, syscall_out, halt, sel,
    input  seg, an, busy
  );
  modport slave (
    input  total_cycles, uncondi_num, condi_num, condi_suc_num, syscall_out, halt, sel,
    output seg, an, busy
  );
endinterface

// File: rtl/stat_display_bin2bcd.sv
// bin2bcd_seq: sequential 32-bit binary to 8-digit packed BCD converter, one shift-add-3 step per cycle
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic [31:0] bcd,
  output logic        done
);
  logic [31:0] bin, adj;
  logic [4:0]  cnt;
  logic        run;
  // add 3 to every digit of 5 or more before the next shift; done flags the edge doing the last step
  always_comb begin
    for (int i = 0; i < 8; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    done = run && cnt == 5'd31;
  end
  // load on start, then 32 shifts of the combined bcd:bin register
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      bin <= value;
      bcd <= '0;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      {bcd, bin} <= {adj[30:0], bin, 1'b0};
      cnt <= cnt + 5'd1;
      run <= cnt != 5'd31;
    end
endmodule

// File: rtl/stat_display.sv
// stat_display: samples a statistic and scans it onto an 8-digit 7-segment display; define STAT_DISPLAY_BCD_EN for decimal mode
module stat_display
  import stat_display_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int UPDATE_DIV = 5000000
) (
  input logic           clk,
  input logic           rst,
  stat_display_if.slave s
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int UW = $clog2(UPDATE_DIV);
  logic [SW-1:0] scan_cnt;
  logic [UW-1:0] upd_cnt;
  logic [2:0]    sel_q, idx;
  logic          halt_q, evt, scan_hit, upd_hit;
  logic [31:0]   src, disp;
  logic [3:0]    nib;
  logic [7:0]    blank;
  // source mux, sample-event detection and the digit about to be lit
  always_comb begin
    src = s.sel == SEL_TOTAL    ? s.total_cycles :
          s.sel == SEL_UNCOND   ? s.uncondi_num :
          s.sel == SEL_COND     ? s.condi_num :
          s.sel == SEL_COND_SUC ? s.condi_suc_num :
          s.sel == SEL_SYSCALL  ? s.syscall_out : 32'd0;
    upd_hit = upd_cnt == UW'(UPDATE_DIV - 1);
    scan_hit = scan_cnt == SW'(SCAN_DIV - 1);
    evt = upd_hit || sel_q != s.sel || (s.halt && !halt_q);
    nib = disp[{idx, 2'b00} +: 4];
    blank = '0;
`ifdef STAT_DISPLAY_BCD_EN
    for (int i = 1; i < 8; i++) blank[i] = (disp >> (4 * i)) == 32'd0;
`endif
  end
  // free-running dividers, edge-detect history and registered digit scan
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      upd_cnt <= '0;
      scan_cnt <= '0;
      sel_q <= '0;
      halt_q <= 1'b0;
      idx <= '0;
      s.seg <= 8'hFF;
      s.an <= 8'hFF;
    end else begin
      upd_cnt <= upd_hit ? '0 : upd_cnt + 1'b1;
      scan_cnt <= scan_hit ? '0 : scan_cnt + 1'b1;
      sel_q <= s.sel;
      halt_q <= s.halt;
      if (scan_hit) begin
        idx <= idx + 3'd1;
        s.an <= ~(8'd1 << idx);
        s.seg <= blank[idx] ? 8'hFF : SEG_TBL[nib];
      end
    end
`ifdef STAT_DISPLAY_BCD_EN
  state_e      state;
  logic        pending, start, done;
  logic [31:0] bcd;
  assign start = state == IDLE && (evt || pending);
  bin2bcd_seq u_conv (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .value(src > BCD_SAT ? BCD_SAT : src),
    .bcd  (bcd),
    .done (done)
  );
  // start a conversion when idle, hold one merged event while busy, load the digits when finished
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      pending <= 1'b0;
      s.busy <= 1'b0;
      disp <= '0;
    end else if (start) begin
      state <= CONV;
      pending <= 1'b0;
      s.busy <= 1'b1;
    end else begin
      pending <= pending || evt;
      if (state == CONV && done) state <= LOAD;
      if (state == LOAD) begin
        state <= IDLE;
        disp <= bcd;
        s.busy <= 1'b0;
      end
    end
`else
  assign s.busy = 1'b0;
  // hex mode: the display register is the snapshot itself
  always_ff @(posedge clk or negedge rst)
    if (!rst) disp <= '0;
    else if (evt) disp <= src;
`endif
endmodule

// File: doc/stat_display.md
# stat_display

Downstream consumer of the pipeline statistics unit: samples one of the five 32-bit statistic outputs (cycle count, unconditional/conditional/taken-branch counts, syscall display value), converts it to hex or decimal digits and drives an 8-digit multiplexed 7-segment display. It sits at the top of the CPU on the board side and has no effect on pipeline behaviour.

## Interface
- SCAN_DIV, 100000: clk cycles per digit slot (≥2).
- UPDATE_DIV, 5000000: clk cycles between periodic samples (≥64).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- total_cycles, uncondi_num, condi_num, condi_suc_num, syscall_out  in  32 each  statistic values.
- halt  in  1  CPU halt flag.
- sel  in  3  source select: 0 total_cycles, 1 uncondi_num, 2 condi_num, 3 condi_suc_num, 4 syscall_out, 5–7 constant 0.
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- an  out  8  digit enables, active-low, bit i = digit i (digit 0 rightmost).
- busy  out  1  conversion in progress.

## Operation
- Sample event: update counter reaches UPDATE_DIV−1 (then wraps to 0), OR registered sel differs from sel, OR halt rising edge. Multiple causes in one cycle = one event.
- Event while busy: one-deep pending flag set; served on the first IDLE cycle; further events while pending are merged.
- Sampled value = selected source at the event edge, held in snapshot register.
- FSM (decimal mode): IDLE → CONV on event; CONV runs 32 shift-add-3 iterations, one per cycle; CONV → LOAD after iteration 32; LOAD copies 8 BCD digits to display register, → IDLE.
- Decimal saturation: snapshot > 99999999 loads 99999999 into the converter.
- Decimal leading-zero blanking: digits above the most significant nonzero digit are blank (seg=8'hFF); digit 0 always shown.
- Hex mode: display register = snapshot nibbles, digit i = bits [4i+3:4i]; no blanking.
- Scan: scan counter wraps at SCAN_DIV−1; on wrap, digit index increments 0→7→0 and an = ~(1<<index), seg = decoded digit. dp always off.
- Segment patterns: standard 0–9, A–F (b, d lowercase).

## Timing
- Reset: seg=8'hFF, an=8'hFF, busy=0, FSM IDLE, display register 0, digit index 0, all counters 0, pending 0, sel_q=0.
- Reset deassert mid-conversion: conversion discarded, display register 0.
- Decimal latency: event at edge T → busy=1 from T through T+32, display register updated at edge T+33, busy=0 after T+33.
- Hex latency: display register updated at the event edge; busy constant 0.
- First an/seg change after reset: edge SCAN_DIV (digit 0 lit).
- Display register change takes effect on the digit currently lit at the next scan wrap (seg is registered at scan wrap only).

## Configuration
- STAT_DISPLAY_BCD_EN defined: decimal mode, sequential converter, saturation and leading-zero blanking as above.
- Undefined: hex mode only; converter, FSM and pending logic not compiled; busy tied 0.

## Structure
- Package stat_display_pkg: sel encodings (SEL_TOTAL..SEL_SYSCALL), 16-entry active-low segment constant table, BCD_SAT = 99999999.
- Sub-module bin2bcd_seq (start, 32-bit value in, 32-bit packed BCD out, done), instantiated only under STAT_DISPLAY_BCD_EN.

## Test plan
- Bench SCAN_DIV=4, UPDATE_DIV=64.
- Reset release, no events: an=8'hFF until edge 4, then 8'hFE; seg shows "0" on digit 0, blanks elsewhere (decimal).
- Decimal, sel=0, total_cycles=12345678 at sample: busy high 33 cycles, then scan shows digits 8,7,6,5,4,3,2,1 on digits 0–7.
- Decimal, syscall_out=32'hFFFFFFFF, sel=4: display 99999999 (saturation).
- Hex build, condi_num=32'hDEADBEEF, sel 0→2: display register updated same edge sel_q differs, digits F,E,E,B,D,A,E,D; busy never asserts.
- Decimal, sel changes twice and halt rises during a conversion: exactly one extra conversion follows, result = value sampled at first IDLE cycle.
- Assert rst low mid-CONV: all outputs to reset values immediately; after release, shows 0.
